pwm_multi: RTL and testbench
============================

# pwm_multi

Parametrised multi-channel PWM generator, the successor to the single-channel 8-bit `pwm` block. It drives CHANNELS outputs of WIDTH-bit resolution from one shared prescaled counter. Duty updates are double-buffered so they take effect only at a period boundary, giving glitch-free changes. It sits beside the I2C register bank in the toi2s FPGA/TT wrapper; duty, prescale, invert and enable come from `sys_cfg` fields.

## Interface
Parameters:
- WIDTH, 8, duty/counter resolution in bits; period is 2^WIDTH counter steps.
- CHANNELS, 4, number of PWM outputs; power of two, ≤ 2^WIDTH.
- PRESCALE_W, 8, width of the prescale input.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run when high; when low, counters are held and outputs idle.
- prescale  in  PRESCALE_W  counter step every prescale+1 clk cycles.
- duty  in  CHANNELS*WIDTH  per-channel duty; channel k is bits [k*WIDTH +: WIDTH].
- duty_wr  in  1  one-cycle strobe that captures all of `duty` into the pending register.
- invert  in  CHANNELS  per-channel output polarity inversion.
- pwm_out  out  CHANNELS  PWM outputs, registered.
- period_start  out  1  one-cycle pulse at each period boundary.
- update_done  out  1  one-cycle pulse when pending duty is transferred to the active register.

## Operation
- Prescaler `pre` counts 0..prescale.
  - `tick` is asserted when pre == prescale; pre then returns to 0.
  - When prescale = 0, tick is asserted every cycle.
  - If prescale changes mid-count so that pre > prescale, the next cycle gives tick and pre = 0.
- Main counter `cnt` (WIDTH bits) increments on tick and wraps from 2^WIDTH−1 to 0.
- A boundary is the edge at which cnt wraps to 0, plus the first tick after enable rises.
- Duty buffering:
  - duty_wr stores `duty` into `pending` and sets `pend_valid`.
  - At a boundary with pend_valid set: `active` ← pending, pend_valid is cleared, update_done pulses.
  - duty_wr in the same cycle as a boundary: the new `duty` goes straight into `active` and update_done pulses. pend_valid ends cleared.
  - A second duty_wr before a boundary overwrites pending (last write wins).
- Compare for each channel: raw[k] = (phase_k < active[k]).
  - Duty 0 gives constant low.
  - Duty 2^WIDTH−1 gives high for 2^WIDTH−1 of 2^WIDTH steps.
  - Duty 2^(WIDTH−1) gives exactly 50%.
- Output: pwm_out[k] ← raw[k] XOR invert[k], registered.
- enable low:
  - pre and cnt are held at 0.
  - pwm_out[k] = invert[k].
  - Pending/active keep their values, and duty_wr is still accepted.
- enable rising: counting starts from cnt = 0. The first tick is a boundary, so any pending duty is applied and period_start pulses.
- Reset:
  - pre, cnt, pending and active clear to 0; pend_valid clears.
  - pwm_out = 0 (invert is ignored during reset); period_start = 0; update_done = 0.
  - Reset asserted mid-period aborts the period immediately.

## Timing
- period_start and update_done are registered. Both are high for exactly one clk, in the first cycle in which cnt == 0 after a boundary.
- pwm_out lags cnt/active by one clk (compare, then register).
- The new duty is first visible on pwm_out one cycle after update_done rises.
- Period = (prescale+1)·2^WIDTH clk cycles. High time = active[k]·(prescale+1) cycles.
- duty_wr is sampled on every clk edge. There is no backpressure and no busy signal.

## Configuration
- PWM_STAGGER_EN defined:
  - Channel k uses phase_k = cnt + k·(2^WIDTH / CHANNELS), modulo 2^WIDTH.
  - This spreads rising edges evenly across the period to reduce simultaneous switching.
  - Boundary, period_start and duty update remain tied to cnt, so one channel's update may land mid-pulse for that channel.
- Not defined: phase_k = cnt for all channels, and all channels rise together at cnt = 0.

## Test plan
- Reset and idle: assert reset for 3 cycles with invert=4'b1010, then release with enable=0 → pwm_out = 4'b0000 during reset, 4'b1010 after; period_start never pulses.
- Basic duty: WIDTH=8, prescale=0, duty ch0=0x80, ch1=0x00, ch2=0xFF, ch3=0x01 written, enable=1 → update_done on the first tick; per 256-cycle period, high counts are 128/0/255/1; period_start every 256 cycles.
- Prescale: prescale=3, ch0=0x40 → period 1024 cycles, ch0 high for 256 cycles.
- Double buffering: while running with ch0=0x80, write 0x20 at cnt=0x10, then 0x30 at cnt=0x50 → the current period stays 128 high; from the next boundary ch0 = 0x30 (48 high); a single update_done pulse.
- Simultaneous duty_wr and boundary: duty_wr 0x60 in the wrap cycle → that period's high time is 96; update_done pulses once.
- Stagger (PWM_STAGGER_EN, CHANNELS=4): all duties 0x40 → rising edges of ch0..ch3 at cnt 0, 192, 128, 64 (offset −64·k); each high for 64 cycles. Without the macro, all four rise at cnt=0.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator sharing one prescaled counter.
// Duty values are double-buffered and only change at a period boundary.
// Optional feature macro: PWM_STAGGER_EN spreads channel phases evenly
// across the period; when undefined all channels rise together at cnt = 0.
module pwm_multi #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      duty_wr,
    input  logic [CHANNELS-1:0]       invert,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic                      update_done
);

    localparam int unsigned       STEP    = (2 ** WIDTH) / CHANNELS;
    localparam logic [WIDTH-1:0]  CNT_MAX = '1;

    // Timebase state; armed_q marks "next tick starts a fresh period"
    // (after reset or while enable is low).
    logic [PRESCALE_W-1:0]     pre_q, pre_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    logic                      armed_q, armed_d;

    // Duty double buffer.
    logic [CHANNELS*WIDTH-1:0] pending_q, pending_d;
    logic [CHANNELS*WIDTH-1:0] active_q, active_d;
    logic                      pend_valid_q, pend_valid_d;

    // Registered outputs.
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      period_start_q, period_start_d;
    logic                      update_done_q, update_done_d;

    logic                      tick;
    logic                      boundary;
    logic [WIDTH-1:0]          phase [CHANNELS];

    // Prescaler and main counter; a boundary is the wrap tick or the first
    // tick after enable rises, and in both cases cnt lands on 0.
    always_comb begin
        tick     = enable && (pre_q >= prescale);
        boundary = tick && (armed_q || (cnt_q == CNT_MAX));
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        armed_d  = armed_q;
        if (!enable) begin
            pre_d   = '0;
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (tick) begin
            pre_d   = '0;
            cnt_d   = boundary ? '0 : cnt_q + WIDTH'(1);
            armed_d = 1'b0;
        end else begin
            pre_d   = pre_q + PRESCALE_W'(1);
        end
    end

    // Duty capture and transfer; a write coinciding with a boundary bypasses
    // the pending register so it applies to the period that is starting.
    always_comb begin
        pending_d      = pending_q;
        pend_valid_d   = pend_valid_q;
        active_d       = active_q;
        update_done_d  = 1'b0;
        period_start_d = boundary;
        if (duty_wr) begin
            pending_d    = duty;
            pend_valid_d = 1'b1;
        end
        if (boundary) begin
            if (duty_wr) begin
                active_d      = duty;
                pend_valid_d  = 1'b0;
                update_done_d = 1'b1;
            end else if (pend_valid_q) begin
                active_d      = pending_q;
                pend_valid_d  = 1'b0;
                update_done_d = 1'b1;
            end
        end
    end

    // Per-channel compare and polarity; outputs idle at invert until the
    // first period has actually started.
    always_comb begin
        pwm_d = invert;
        for (int k = 0; k < CHANNELS; k++) begin
`ifdef PWM_STAGGER_EN
            phase[k] = cnt_q + WIDTH'(k * STEP);
`else
            phase[k] = cnt_q;
`endif
            if (enable && !armed_q) begin
                pwm_d[k] = (phase[k] < active_q[k*WIDTH +: WIDTH]) ^ invert[k];
            end
        end
    end

    // State update with synchronous reset; reset aborts any period at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q          <= '0;
            cnt_q          <= '0;
            armed_q        <= 1'b1;
            pending_q      <= '0;
            active_q       <= '0;
            pend_valid_q   <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            update_done_q  <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            armed_q        <= armed_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            pend_valid_q   <= pend_valid_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            update_done_q  <= update_done_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign update_done  = update_done_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: per-period high-time, update and edge checks
// against a duty bookkeeping model held in the bench.
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PW = 8;
    localparam int M  = 256;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [PW-1:0]     prescale;
    logic [CH*W-1:0]   duty;
    logic              duty_wr;
    logic [CH-1:0]     invert;
    logic [CH-1:0]     pwm_out;
    logic              period_start;
    logic              update_done;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .prescale(prescale),
        .duty(duty), .duty_wr(duty_wr), .invert(invert), .pwm_out(pwm_out),
        .period_start(period_start), .update_done(update_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: which duty values are active / pending.
    logic [CH*W-1:0] m_act;
    logic [CH*W-1:0] m_pend;
    bit              m_pv;

    // Measurement results of the last window.
    int              hi [CH];
    int              upd_mid, ps_mid;
    logic            upd_end, ps_end;
    logic [CH-1:0]   win [0:1024];

    function automatic logic [CH*W-1:0] pk(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    // Expected high cycles of channel k over one full period.
    function automatic int exp_hi(input int k, input int pre);
        int d;
        d = int'(m_act[k*W +: W]);
        return invert[k] ? (M * (pre + 1) - d * (pre + 1)) : d * (pre + 1);
    endfunction

    task automatic model_wr(input logic [CH*W-1:0] v);
        m_pend = v;
        m_pv   = 1'b1;
    endtask

    task automatic model_bnd(output bit upd);
        upd = m_pv;
        if (m_pv) m_act = m_pend;
        m_pv = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive_wr(input logic [CH*W-1:0] v);
        duty    = v;
        duty_wr = 1'b1;
        model_wr(v);
        cyc();
        duty_wr = 1'b0;
    endtask

    // Wait (bounded) for period_start; ok=0 on timeout.
    task automatic wait_ps(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            cyc();
            if (period_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Collect one window of P cycles starting just after a period_start,
    // optionally issuing duty writes at window cycles at1/at2.
    task automatic measure(input int P, input int at1, input logic [CH*W-1:0] v1,
                           input int at2, input logic [CH*W-1:0] v2);
        for (int k = 0; k < CH; k++) hi[k] = 0;
        upd_mid = 0;
        ps_mid  = 0;
        win[0]  = pwm_out;
        for (int i = 1; i <= P; i++) begin
            cyc();
            duty_wr = 1'b0;
            win[i]  = pwm_out;
            for (int k = 0; k < CH; k++) if (pwm_out[k]) hi[k]++;
            if (i < P) begin
                if (update_done) upd_mid++;
                if (period_start) ps_mid++;
            end else begin
                upd_end = update_done;
                ps_end  = period_start;
            end
            if (i == at1) begin duty = v1; duty_wr = 1'b1; model_wr(v1); end
            if (i == at2) begin duty = v2; duty_wr = 1'b1; model_wr(v2); end
        end
        duty_wr = 1'b0;
    endtask

    task automatic test_reset();
        int ps_seen;
        reset = 1'b1; enable = 1'b0; invert = 4'b1010; duty_wr = 1'b0;
        duty = '0; prescale = '0;
        m_act = '0; m_pend = '0; m_pv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if ({pwm_out, period_start, update_done} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outputs: got pwm=%b ps=%b ud=%b expected pwm=0000 ps=0 ud=0",
                         pwm_out, period_start, update_done);
            end
        end
        reset = 1'b0;
        cyc(); cyc();
        checks++;
        if (pwm_out !== 4'b1010) begin
            failures++;
            $display("FAIL idle_invert: got %b expected 1010", pwm_out);
        end
        ps_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (period_start !== 1'b0) ps_seen++;
        end
        checks++;
        if (ps_seen != 0) begin
            failures++;
            $display("FAIL idle_period_start: got %0d pulses expected 0", ps_seen);
        end
    endtask

    task automatic test_basic();
        bit u;
        invert = '0; prescale = '0;
        drive_wr(pk(8'h80, 8'h00, 8'hFF, 8'h01));
        enable = 1'b1;
        cyc();
        model_bnd(u);
        checks++;
        if (update_done !== u || period_start !== 1'b1) begin
            failures++;
            $display("FAIL basic_first_tick: got ud=%b ps=%b expected ud=%b ps=1",
                     update_done, period_start, u);
        end
        for (int p = 0; p < 2; p++) begin
            measure(M, -1, '0, -1, '0);
            model_bnd(u);
            for (int k = 0; k < CH; k++) begin
                checks++;
                if (hi[k] != exp_hi(k, 0)) begin
                    failures++;
                    $display("FAIL basic_high ch%0d: got %0d expected %0d", k, hi[k], exp_hi(k, 0));
                end
            end
            checks++;
            if (ps_end !== 1'b1 || ps_mid != 0 || upd_end !== u || upd_mid != 0) begin
                failures++;
                $display("FAIL basic_period: got ps_end=%b ps_mid=%0d ud_end=%b ud_mid=%0d expected 1 0 %b 0",
                         ps_end, ps_mid, upd_end, upd_mid, u);
            end
        end
    endtask

    task automatic test_prescale();
        bit u, ok;
        enable = 1'b0;
        cyc();
        prescale = 8'd3;
        drive_wr(pk(8'h40, W'($urandom), W'($urandom), W'($urandom)));
        enable = 1'b1;
        wait_ps(10, ok);
        model_bnd(u);
        checks++;
        if (!ok || update_done !== u) begin
            failures++;
            $display("FAIL prescale_start: got ok=%0d ud=%b expected ok=1 ud=%b", ok, update_done, u);
        end
        measure(4 * M, -1, '0, -1, '0);
        model_bnd(u);
        checks++;
        if (hi[0] != 256) begin
            failures++;
            $display("FAIL prescale_ch0: got %0d expected 256", hi[0]);
        end
        for (int k = 1; k < CH; k++) begin
            checks++;
            if (hi[k] != exp_hi(k, 3)) begin
                failures++;
                $display("FAIL prescale_high ch%0d: got %0d expected %0d", k, hi[k], exp_hi(k, 3));
            end
        end
        checks++;
        if (ps_end !== 1'b1 || ps_mid != 0) begin
            failures++;
            $display("FAIL prescale_period: got ps_end=%b ps_mid=%0d expected 1 0", ps_end, ps_mid);
        end
    endtask

    task automatic test_double_buffer();
        bit u;
        enable = 1'b0; prescale = '0; invert = '0;
        cyc();
        drive_wr(pk(8'h80, 8'h80, 8'h80, 8'h80));
        enable = 1'b1;
        cyc();
        model_bnd(u);
        measure(M, 16, pk(8'h20, 8'h80, 8'h80, 8'h80), 80, pk(8'h30, 8'h80, 8'h80, 8'h80));
        model_bnd(u);
        checks++;
        if (hi[0] != 128) begin
            failures++;
            $display("FAIL dbuf_current: got %0d expected 128", hi[0]);
        end
        checks++;
        if (upd_mid != 0 || upd_end !== u) begin
            failures++;
            $display("FAIL dbuf_update: got ud_mid=%0d ud_end=%b expected 0 %b", upd_mid, upd_end, u);
        end
        measure(M, -1, '0, -1, '0);
        model_bnd(u);
        checks++;
        if (hi[0] != 48 || hi[0] != exp_hi(0, 0)) begin
            failures++;
            $display("FAIL dbuf_next: got %0d expected 48", hi[0]);
        end
        checks++;
        if (upd_mid != 0 || upd_end !== 1'b0) begin
            failures++;
            $display("FAIL dbuf_single_update: got ud_mid=%0d ud_end=%b expected 0 0", upd_mid, upd_end);
        end
    endtask

    task automatic test_simultaneous();
        bit u;
        measure(M, M - 1, pk(8'h60, 8'h80, 8'h80, 8'h80), -1, '0);
        model_bnd(u);
        checks++;
        if (upd_end !== 1'b1 || upd_mid != 0 || u != 1'b1) begin
            failures++;
            $display("FAIL simul_update: got ud_end=%b ud_mid=%0d expected 1 0", upd_end, upd_mid);
        end
        measure(M, -1, '0, -1, '0);
        model_bnd(u);
        checks++;
        if (hi[0] != 96) begin
            failures++;
            $display("FAIL simul_high: got %0d expected 96", hi[0]);
        end
        checks++;
        if (upd_end !== 1'b0 || upd_mid != 0) begin
            failures++;
            $display("FAIL simul_pend_cleared: got ud_end=%b ud_mid=%0d expected 0 0", upd_end, upd_mid);
        end
    endtask

    task automatic test_stagger();
        bit u;
        int rise, off;
        measure(M, 100, pk(8'h40, 8'h40, 8'h40, 8'h40), -1, '0);
        model_bnd(u);
        measure(M, -1, '0, -1, '0);
        model_bnd(u);
        for (int k = 0; k < CH; k++) begin
`ifdef PWM_STAGGER_EN
            off = (M - k * (M / CH)) % M;
`else
            off = 0;
`endif
            rise = -1;
            for (int i = 1; i <= M; i++)
                if (rise < 0 && win[i][k] && !win[i-1][k]) rise = i;
            checks++;
            if (rise != off + 1 || hi[k] != 64) begin
                failures++;
                $display("FAIL stagger ch%0d: got rise=%0d high=%0d expected rise=%0d high=64",
                         k, rise, hi[k], off + 1);
            end
        end
    endtask

    task automatic test_enable_low();
        bit u, ok;
        int pre, ps_seen;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 50; i++) cyc();
            enable = 1'b0;
            invert = CH'($urandom);
            cyc(); cyc();
            checks++;
            if (pwm_out !== invert) begin
                failures++;
                $display("FAIL disabled_idle: got %b expected %b", pwm_out, invert);
            end
            drive_wr(pk(W'($urandom), W'($urandom), W'($urandom), W'($urandom)));
            drive_wr(pk(W'($urandom), W'($urandom), W'($urandom), W'($urandom)));
            ps_seen = 0;
            for (int i = 0; i < 30; i++) begin
                cyc();
                if (period_start) ps_seen++;
            end
            checks++;
            if (ps_seen != 0 || pwm_out !== invert) begin
                failures++;
                $display("FAIL disabled_hold: got ps=%0d pwm=%b expected ps=0 pwm=%b", ps_seen, pwm_out, invert);
            end
            pre = int'($urandom_range(3, 0));
            prescale = PW'(pre);
            enable = 1'b1;
            wait_ps(10, ok);
            model_bnd(u);
            checks++;
            if (!ok || update_done !== u) begin
                failures++;
                $display("FAIL enable_start: got ok=%0d ud=%b expected ok=1 ud=%b", ok, update_done, u);
            end
            for (int p = 0; p < 2; p++) begin
                measure(M * (pre + 1), -1, '0, -1, '0);
                model_bnd(u);
                for (int k = 0; k < CH; k++) begin
                    checks++;
                    if (hi[k] != exp_hi(k, pre)) begin
                        failures++;
                        $display("FAIL rand_high r%0d ch%0d: got %0d expected %0d", r, k, hi[k], exp_hi(k, pre));
                    end
                end
                checks++;
                if (ps_end !== 1'b1 || ps_mid != 0 || upd_end !== u) begin
                    failures++;
                    $display("FAIL rand_period r%0d: got ps_end=%b ps_mid=%0d ud=%b expected 1 0 %b",
                             r, ps_end, ps_mid, upd_end, u);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int i = 0; i < 70; i++) cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (pwm_out !== 4'b0000 || period_start !== 1'b0 || update_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got pwm=%b ps=%b ud=%b expected 0000 0 0", pwm_out, period_start, update_done);
        end
        cyc();
        m_act = '0; m_pend = '0; m_pv = 1'b0;
        invert = '0; prescale = '0; enable = 1'b1;
        reset = 1'b0;
        wait_ps(10, ok);
        checks++;
        if (!ok || update_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_restart: got ok=%0d ud=%b expected ok=1 ud=0", ok, update_done);
        end
        measure(M, -1, '0, -1, '0);
        checks++;
        if (hi[0] + hi[1] + hi[2] + hi[3] != 0 || ps_end !== 1'b1) begin
            failures++;
            $display("FAIL reset_cleared_duty: got high=%0d ps_end=%b expected 0 1",
                     hi[0] + hi[1] + hi[2] + hi[3], ps_end);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_prescale();
        test_double_buffer();
        test_simultaneous();
        test_stagger();
        test_enable_low();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
